// File: rtl/rv_pkg.sv
// Shared integer register-file types and sizes for the write-back path.
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic            valid;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grant is combinational from req and last_gnt.
// last_gnt resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_gnt;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     last_gnt <= 1'b1;
    else if (gnt[0]) last_gnt <= 1'b0;
    else if (gnt[1]) last_gnt <= 1'b1;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (ALU vs LSU) plus pending-destination scoreboard.
// Write commits one cycle after acceptance; issue stalls while its rd is still pending.
module rf_wb_arbiter
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              wb0_valid,
  input  logic [REG_AW-1:0] wb0_rd,
  input  logic [XLEN-1:0]   wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_AW-1:0] wb1_rd,
  input  logic [XLEN-1:0]   wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);
  wb_req_t         wb0, wb1;
  logic [1:0]      gnt;
  logic            accept;
  reg_addr_t       sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] pending, pending_nxt;

  assign wb0 = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
  assign wb1 = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({wb1.valid, wb0.valid}),
    .gnt    (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign accept    = |gnt;
  assign sel_rd    = gnt[1] ? wb1.rd   : wb0.rd;
  assign sel_data  = gnt[1] ? wb1.data : wb0.data;

  // Busy flags read the registered scoreboard only; a same-cycle clear is not bypassed.
  assign iss_ready = !pending[iss_rd];
  assign rs1_busy  = pending[rs1_addr];
  assign rs2_busy  = pending[rs2_addr];

  // Clear applied before set: a same-edge re-issue of the retiring rd stays pending.
  always_comb begin
    pending_nxt = pending;
    if (accept && sel_rd != '0) pending_nxt[sel_rd] = 1'b0;
    if (iss_valid && iss_ready && iss_rd != '0) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending <= '0;
    else         pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= accept && (sel_rd != '0);
      if (accept) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios plus constrained-random traffic against a behavioural model.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  rf_wb_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: set of pending registers, round-robin pointer, expected write port.
  bit          m_pend [32];
  bit          m_last;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          mg0, mg1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last  = 1'b1;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    bit e_ir, e_g0, e_g1;
    int g;
    @(negedge clk);
    if (!resetn) model_reset();
    e_ir = (iss_rd == 0) || !m_pend[iss_rd];
    e_g0 = wb0_valid && (!wb1_valid || m_last);
    e_g1 = wb1_valid && (!wb0_valid || !m_last);
    chk("iss_ready", 32'(iss_ready), 32'(e_ir));
    chk("rs1_busy",  32'(rs1_busy),  32'(m_pend[rs1_addr]));
    chk("rs2_busy",  32'(rs2_busy),  32'(m_pend[rs2_addr]));
    chk("wb0_ready", 32'(wb0_ready), 32'(e_g0));
    chk("wb1_ready", 32'(wb1_ready), 32'(e_g1));
    chk("rf_we",     32'(rf_we),     32'(m_we));
    chk("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
    chk("rf_wdata",  rf_wdata,       m_wdata);
    mg0 = e_g0;
    mg1 = e_g1;
    if (resetn) begin
      g = e_g0 ? 0 : (e_g1 ? 1 : -1);
      m_we = 1'b0;
      if (g >= 0) begin
        m_waddr = (g == 0) ? wb0_rd : wb1_rd;
        m_wdata = (g == 0) ? wb0_data : wb1_data;
        m_we    = (m_waddr != 0);
        m_last  = (g == 1);
        if (m_waddr != 0) m_pend[m_waddr] = 1'b0;
      end
      if (iss_valid && e_ir && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  initial begin
    bit hold0, hold1;
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Read-after-write on x7
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0; rs1_addr = 7;
    wb1_valid = 1; wb1_rd = 7; wb1_data = 32'hDEADBEEF;
    tick();
    wb1_valid = 0;
    tick();

    // Contention: each side presents a fresh pair once accepted
    wb0_valid = 1; wb0_rd = 3; wb0_data = 32'h11;
    wb1_valid = 1; wb1_rd = 4; wb1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mg0) begin wb0_rd = wb0_rd + 5'd2; wb0_data = wb0_data + 32'h100; end
      if (mg1) begin wb1_rd = wb1_rd + 5'd2; wb1_data = wb1_data + 32'h100; end
    end
    wb0_valid = 0; wb1_valid = 0;
    tick();

    // Write-after-write block on x10
    iss_valid = 1; iss_rd = 10;
    tick();
    tick();
    wb0_valid = 1; wb0_rd = 10; wb0_data = 32'hA5A5;
    tick();
    wb0_valid = 0;
    tick();
    iss_valid = 0;
    wb0_valid = 1;
    tick();
    wb0_valid = 0;

    // Set/clear collision on x12 (not pending beforehand)
    iss_valid = 1; iss_rd = 12; rs2_addr = 12;
    wb0_valid = 1; wb0_rd = 12; wb0_data = 32'h1212;
    tick();
    iss_valid = 0; wb0_valid = 0;
    tick();
    wb1_valid = 1; wb1_rd = 12;
    tick();
    wb1_valid = 0;

    // x0 write from the LSU
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'hFFFFFFFF;
    tick();
    wb1_valid = 0;
    tick();

    // Reset mid-stream with x5, x9 pending and a grant in the same cycle
    iss_valid = 1; iss_rd = 5;
    tick();
    iss_rd = 9;
    tick();
    iss_valid = 0; rs1_addr = 5; rs2_addr = 9;
    wb1_valid = 1; wb1_rd = 3; wb1_data = 32'h33;
    tick();
    resetn = 1'b0;
    wb1_valid = 1; wb1_rd = 5; wb1_data = 32'h55;
    tick();
    resetn = 1'b1;
    wb0_valid = 1; wb0_rd = 6; wb0_data = 32'h66;
    wb1_valid = 1;
    tick();
    idle_inputs();
    tick();

    // Random traffic honouring the hold-while-denied rule
    hold0 = 0; hold1 = 0;
    for (int n = 0; n < 600; n++) begin
      iss_valid = ($urandom_range(0, 99) < 60);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 31));
      if (!hold0) begin
        wb0_valid = ($urandom_range(0, 99) < 55);
        wb0_rd    = 5'($urandom_range(0, 7));
        wb0_data  = $urandom;
      end
      if (!hold1) begin
        wb1_valid = ($urandom_range(0, 99) < 55);
        wb1_rd    = 5'($urandom_range(0, 7));
        wb1_data  = $urandom;
      end
      if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      else                             resetn = 1'b1;
      tick();
      hold0 = wb0_valid && !mg0 && resetn;
      hold1 = wb1_valid && !mg1 && resetn;
    end
    resetn = 1'b1;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
